sr_latch: RTL and testbench
===========================

Name: sr_latch

Overview:
- Clocked, synchronous replacement for a set/reset latch, packaged as a bank of WIDTH independent SR cells.
- Used in the magnetron control path to remember "on" and "off" requests between events. Default WIDTH=1 gives a single-bit drop-in cell.
- Each cell: set forces Q=1, reset forces Q=0, neither holds, both resolves by the PRIORITY parameter.
- Also provides complementary outputs and single-cycle edge pulses for downstream logic.

Parameters:
- WIDTH, 1, number of independent SR cells (1..32).
- RESET_DOMINANT, 1, when set and reset are both 1: 1 = reset wins (Q=0), 0 = set wins (Q=1).
- INIT_VALUE, 0, WIDTH-bit value loaded into Q by rst.
- SYNC_STAGES, 0, flip-flop synchronizer depth on set/reset inputs (0..3); 0 = inputs used directly.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, asynchronous active-high global clear; Q forced to INIT_VALUE immediately.
- set, input, WIDTH, per-cell set request, active-high, level-sensitive.
- reset, input, WIDTH, per-cell clear request, active-high, level-sensitive. This is a functional input, distinct from rst.
- Q, output, WIDTH, stored state per cell.
- Q_n, output, WIDTH, bitwise complement of Q.
- rise, output, WIDTH, one-cycle pulse when a cell's Q goes 0->1.
- fall, output, WIDTH, one-cycle pulse when a cell's Q goes 1->0.

Behaviour:
- rst=1, asynchronous: Q=INIT_VALUE, Q_n=~INIT_VALUE, rise=0, fall=0, synchronizer stages cleared to 0. Held for as long as rst is 1; set/reset are ignored.
- rst deassertion: synchronous with respect to clk; first update on the first rising edge with rst=0.
- Input path: s_eff/r_eff = set/reset delayed through SYNC_STAGES flops (per bit). With SYNC_STAGES=0 they equal set/reset.
- Per-cell next state, evaluated at each rising clk edge:
  - s=0, r=0: hold Q.
  - s=0, r=1: Q <= 0.
  - s=1, r=0: Q <= 1.
  - s=1, r=1: Q <= (RESET_DOMINANT ? 0 : 1).
- Latency: a request applied before edge k appears on Q after edge k+SYNC_STAGES. Default latency is 1 clock.
- Q_n is combinational ~Q, never registered separately, so it is always the exact complement.
- rise/fall are registered alongside Q:
  - rise[i]=1 for exactly the cycle after Q[i] changed 0->1.
  - fall[i]=1 for exactly the cycle after Q[i] changed 1->0.
  - Both are 0 when Q is unchanged, including repeated set while Q=1 and repeated reset while Q=0.
  - rise and fall are never 1 simultaneously for the same bit.
- Input pulses shorter than one clock period that miss a rising edge are lost. This is by design.
- Cells are fully independent; no cross-bit interaction.
- rst asserted mid-operation, including during an active request: immediate clear, and no rise/fall pulse is generated for the reset-induced change.
- No X propagation: after rst, all outputs are defined regardless of the input values.

Decomposition:
- Shared package sr_latch_pkg holds the priority constants RESET_WINS=1 and SET_WINS=0 and the default WIDTH.
- One natural sub-module: sr_cell, a single-bit cell with synchronizer, next-state logic and edge pulse.
- sr_latch instantiates WIDTH sr_cell copies in a generate loop.

Test Plan:
- rst pulse with set=0, reset=0, INIT_VALUE=0 -> Q=0, Q_n=1, rise=fall=0 asynchronously, with no clock edge needed.
- From Q=0: set=0, reset=1 for one cycle, then 0/0 -> Q stays 0, no pulses; then set=1, reset=0 for one cycle -> Q=1 one edge later, rise=1 for one cycle; then set=0, reset=0 -> Q holds 1.
- From Q=1: set=1, reset=1 with RESET_DOMINANT=1 -> Q=0 and fall=1 for one cycle. With RESET_DOMINANT=0, Q stays 1 and no pulse.
- Repeat set=1 for 5 cycles -> rise=1 only in the first cycle after the transition; Q=1 throughout.
- WIDTH=4, SYNC_STAGES=2: set=4'b0101, then reset=4'b0100 -> Q=4'b0101 two edges after the set is applied, then Q=4'b0001; only bit 2 shows fall.
- Assert rst while Q=1 and set=1 is held -> Q=0 immediately, fall=0; after rst drops, Q=1 on the next edge with rise=1.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// Shared definitions for the sr_latch bank: priority constants, the request
// encoding and the per-cell next-state rule used by every sr_cell.
package sr_latch_pkg;

    localparam bit RESET_WINS    = 1'b1;
    localparam bit SET_WINS      = 1'b0;
    localparam int DEFAULT_WIDTH = 1;

    typedef enum logic [1:0] {
        REQ_HOLD  = 2'b00,
        REQ_CLEAR = 2'b01,
        REQ_SET   = 2'b10,
        REQ_BOTH  = 2'b11
    } req_e;

    // Simultaneous set and clear resolves to the complement of the priority flag.
    function automatic logic resolveNext(input logic s, input logic r,
                                         input logic q, input logic resetDominant);
        req_e req;
        req = req_e'({s, r});
        case (req)
            REQ_HOLD:  return q;
            REQ_CLEAR: return 1'b0;
            REQ_SET:   return 1'b1;
            REQ_BOTH:  return ~resetDominant;
            default:   return q;
        endcase
    endfunction

endpackage

// File: rtl/sr_latch_cell.sv
// Single-bit clocked SR cell: optional input synchronizer, next-state rule
// and registered rise/fall pulses that track the stored bit.
module sr_cell
    import sr_latch_pkg::*;
#(
    parameter bit RESET_DOMINANT = RESET_WINS,
    parameter bit INIT_VALUE     = 1'b0,
    parameter int SYNC_STAGES    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic set_i,
    input  logic reset_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic sEff;
    logic rEff;
    logic q_q;
    logic q_d;
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    generate
        if (SYNC_STAGES == 0) begin : gDirect
            assign sEff = set_i;
            assign rEff = reset_i;
        end else begin : gSync
            logic [SYNC_STAGES-1:0] sSync_q;
            logic [SYNC_STAGES-1:0] rSync_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sSync_q <= '0;
                    rSync_q <= '0;
                end else begin
                    sSync_q[0] <= set_i;
                    rSync_q[0] <= reset_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sSync_q[i] <= sSync_q[i-1];
                        rSync_q[i] <= rSync_q[i-1];
                    end
                end
            end

            assign sEff = sSync_q[SYNC_STAGES-1];
            assign rEff = rSync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        q_d    = resolveNext(sEff, rEff, q_q, RESET_DOMINANT);
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    // Pulses are cleared by rst so a reset-induced change never produces an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= INIT_VALUE;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q_o    = q_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sr_latch.sv
// Bank of WIDTH independent clocked SR cells with complementary outputs and
// single-cycle edge pulses for the magnetron on/off request path.
module sr_latch
    import sr_latch_pkg::*;
#(
    parameter int               WIDTH          = DEFAULT_WIDTH,
    parameter bit               RESET_DOMINANT = RESET_WINS,
    parameter logic [WIDTH-1:0] INIT_VALUE     = '0,
    parameter int               SYNC_STAGES    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] reset,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : gCell
        sr_cell #(
            .RESET_DOMINANT(RESET_DOMINANT),
            .INIT_VALUE    (INIT_VALUE[i]),
            .SYNC_STAGES   (SYNC_STAGES)
        ) uCell (
            .clk    (clk),
            .rst    (rst),
            .set_i  (set[i]),
            .reset_i(reset[i]),
            .q_o    (Q[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    // Derived from Q rather than stored so it can never disagree with it.
    assign Q_n = ~Q;

endmodule

// File: tb/tb_sr_latch.sv
// Scoreboard bench for sr_latch: three configurations driven side by side,
// expected outputs queued at drive time and checked after each edge.
module tb_sr_latch;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       setA = 1'b0, resetA = 1'b0;
    logic       QA, QnA, riseA, fallA;
    logic       setB = 1'b0, resetB = 1'b0;
    logic       QB, QnB, riseB, fallB;
    logic [3:0] setC = '0, resetC = '0;
    logic [3:0] QC, QnC, riseC, fallC;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         dut;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t sbQ[$];

    logic [3:0] mQ[3];
    logic [3:0] mRise[3];
    logic [3:0] mFall[3];
    logic [3:0] sPipe[3][3];
    logic [3:0] rPipe[3][3];
    int         mWidth[3] = '{1, 1, 4};
    bit         mRd[3]    = '{1'b1, 1'b0, 1'b1};
    int         mSs[3]    = '{0, 0, 2};

    always #5 clk = ~clk;

    sr_latch #(.WIDTH(1), .RESET_DOMINANT(1'b1), .INIT_VALUE(1'b0), .SYNC_STAGES(0)) dutA (
        .clk(clk), .rst(rst), .set(setA), .reset(resetA),
        .Q(QA), .Q_n(QnA), .rise(riseA), .fall(fallA));

    sr_latch #(.WIDTH(1), .RESET_DOMINANT(1'b0), .INIT_VALUE(1'b0), .SYNC_STAGES(0)) dutB (
        .clk(clk), .rst(rst), .set(setB), .reset(resetB),
        .Q(QB), .Q_n(QnB), .rise(riseB), .fall(fallB));

    sr_latch #(.WIDTH(4), .RESET_DOMINANT(1'b1), .INIT_VALUE(4'b0000), .SYNC_STAGES(2)) dutC (
        .clk(clk), .rst(rst), .set(setC), .reset(resetC),
        .Q(QC), .Q_n(QnC), .rise(riseC), .fall(fallC));

    function automatic logic [3:0] widthMask(input int d);
        return (mWidth[d] == 4) ? 4'hF : 4'h1;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 3; d++) begin
            mQ[d] = '0; mRise[d] = '0; mFall[d] = '0;
            for (int k = 0; k < 3; k++) begin
                sPipe[d][k] = '0;
                rPipe[d][k] = '0;
            end
        end
    endtask

    task automatic modelStep(input int d, input logic [3:0] s, input logic [3:0] r);
        logic [3:0] mask, se, re, setWinsBoth, nq;
        exp_t e;
        mask        = widthMask(d);
        se          = (mSs[d] == 0) ? (s & mask) : sPipe[d][mSs[d]-1];
        re          = (mSs[d] == 0) ? (r & mask) : rPipe[d][mSs[d]-1];
        setWinsBoth = mRd[d] ? 4'h0 : 4'hF;
        nq = ((se & ~re) | (se & re & setWinsBoth) | (~se & ~re & mQ[d])) & mask;
        mRise[d] = nq & ~mQ[d];
        mFall[d] = ~nq & mQ[d] & mask;
        mQ[d]    = nq;
        for (int k = 2; k > 0; k--) begin
            sPipe[d][k] = sPipe[d][k-1];
            rPipe[d][k] = rPipe[d][k-1];
        end
        sPipe[d][0] = s & mask;
        rPipe[d][0] = r & mask;
        e.dut = d; e.q = mQ[d]; e.rise = mRise[d]; e.fall = mFall[d];
        sbQ.push_back(e);
    endtask

    task automatic checkConst(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [3:0] oq, oqn, orise, ofall;
        for (int n = 0; n < 3; n++) begin
            if (sbQ.size() == 0) begin
                checkConst("scoreboard_empty", 4'h1, 4'h0);
                return;
            end
            e = sbQ.pop_front();
            case (e.dut)
                0:       begin oq = {3'b0, QA}; oqn = {3'b0, QnA}; orise = {3'b0, riseA}; ofall = {3'b0, fallA}; end
                1:       begin oq = {3'b0, QB}; oqn = {3'b0, QnB}; orise = {3'b0, riseB}; ofall = {3'b0, fallB}; end
                default: begin oq = QC; oqn = QnC; orise = riseC; ofall = fallC; end
            endcase
            checkConst($sformatf("dut%0d_Q", e.dut), oq, e.q);
            checkConst($sformatf("dut%0d_Qn", e.dut), oqn, ~e.q & widthMask(e.dut));
            checkConst($sformatf("dut%0d_rise", e.dut), orise, e.rise);
            checkConst($sformatf("dut%0d_fall", e.dut), ofall, e.fall);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic sa, input logic ra, input logic sb, input logic rb,
                                 input logic [3:0] sc, input logic [3:0] rc);
        setA = sa; resetA = ra;
        setB = sb; resetB = rb;
        setC = sc; resetC = rc;
        modelStep(0, {3'b0, sa}, {3'b0, ra});
        modelStep(1, {3'b0, sb}, {3'b0, rb});
        modelStep(2, sc, rc);
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkConst({tag, "_QA"}, {3'b0, QA}, 4'h0);
        checkConst({tag, "_QnA"}, {3'b0, QnA}, 4'h1);
        checkConst({tag, "_riseA"}, {3'b0, riseA}, 4'h0);
        checkConst({tag, "_fallA"}, {3'b0, fallA}, 4'h0);
        checkConst({tag, "_QB"}, {3'b0, QB}, 4'h0);
        checkConst({tag, "_QC"}, QC, 4'h0);
        checkConst({tag, "_QnC"}, QnC, 4'hF);
        checkConst({tag, "_riseC"}, riseC, 4'h0);
        checkConst({tag, "_fallC"}, fallC, 4'h0);
    endtask

    initial begin
        modelReset();
        #2;
        rst = 1'b1;
        #1;
        checkResetState("rst_async");
        @(posedge clk);
        #1;
        checkResetState("rst_held");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        checkConst("clear_from0_QA", {3'b0, QA}, 4'h0);
        checkConst("clear_from0_fallA", {3'b0, fallA}, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100);
        checkConst("set_QA", {3'b0, QA}, 4'h1);
        checkConst("set_riseA", {3'b0, riseA}, 4'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        checkConst("hold_QA", {3'b0, QA}, 4'h1);
        checkConst("hold_riseA", {3'b0, riseA}, 4'h0);
        checkConst("sync_set_QC", QC, 4'b0101);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
        checkConst("both_rdom_QA", {3'b0, QA}, 4'h0);
        checkConst("both_rdom_fallA", {3'b0, fallA}, 4'h1);
        checkConst("both_sdom_QB", {3'b0, QB}, 4'h1);
        checkConst("both_sdom_fallB", {3'b0, fallB}, 4'h0);
        checkConst("sync_clear_QC", QC, 4'b0001);
        checkConst("sync_clear_fallC", fallC, 4'b0100);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
            checkConst($sformatf("repeat_set%0d_QA", i), {3'b0, QA}, 4'h1);
            checkConst($sformatf("repeat_set%0d_riseA", i), {3'b0, riseA}, (i == 0) ? 4'h1 : 4'h0);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000);
        checkConst("preRst_QA", {3'b0, QA}, 4'h1);
        rst = 1'b1;
        #1;
        checkResetState("rst_mid");
        modelReset();
        @(posedge clk);
        #1;
        checkResetState("rst_mid_held");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        checkConst("postRst_QA", {3'b0, QA}, 4'h1);
        checkConst("postRst_riseA", {3'b0, riseA}, 4'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        checkConst("final_fallA", {3'b0, fallA}, 4'h1);
        checkConst("final_QnA", {3'b0, QnA}, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
